// File: rtl/stream_demux_1x2.sv
// stream_demux_1x2: packet-locked 1-to-2 stream demux with per-channel output registers and packet counters
module stream_demux_1x2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              sel,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m0_data,
  output logic              m0_last,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic              m1_last,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t state;
  logic tgt, acc, load0, load1, pop0, pop1;
  always_comb begin
    tgt = state == LOCK1 ? 1'b1 : state == LOCK0 ? 1'b0 : sel;
    pop0 = m0_valid && m0_ready;
    pop1 = m1_valid && m1_ready;
    s_ready = !rst && (tgt ? (!m1_valid || m1_ready) : (!m0_valid || m0_ready));
    acc = s_valid && s_ready;
    load0 = acc && !tgt;
    load1 = acc && tgt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m0_valid <= 1'b0;
      m0_data <= '0;
      m0_last <= 1'b0;
      m1_valid <= 1'b0;
      m1_data <= '0;
      m1_last <= 1'b0;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (acc) state <= s_last ? IDLE : state == IDLE ? (sel ? LOCK1 : LOCK0) : state;
      if (load0) begin
        m0_valid <= 1'b1;
        m0_data <= s_data;
        m0_last <= s_last;
      end else if (pop0) m0_valid <= 1'b0;
      if (load1) begin
        m1_valid <= 1'b1;
        m1_data <= s_data;
        m1_last <= s_last;
      end else if (pop1) m1_valid <= 1'b0;
      if (pop0 && m0_last) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (pop1 && m1_last) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_stream_demux_1x2.sv
// tb_stream_demux_1x2: directed vector table plus hand sequences for reset and counter wrap
module tb_stream_demux_1x2;
  logic clk = 0, rst = 1;
  logic s_valid = 0, s_last = 0, sel = 0, m0_ready = 0, m1_ready = 0;
  logic [7:0] s_data = 0;
  logic s_ready, m0_valid, m0_last, m1_valid, m1_last;
  logic [7:0] m0_data, m1_data, pkt_cnt0, pkt_cnt1;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  stream_demux_1x2 dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .sel(sel), .m0_valid(m0_valid), .m0_ready(m0_ready),
    .m0_data(m0_data), .m0_last(m0_last), .m1_valid(m1_valid), .m1_ready(m1_ready),
    .m1_data(m1_data), .m1_last(m1_last), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );
  typedef struct {
    logic v; logic [7:0] d; logic l; logic sel; logic r0; logic r1;
    logic rdy; logic [35:0] exp;
  } vec_t;
  vec_t q[$];
  function automatic logic [35:0] outs();
    return {m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last, pkt_cnt0, pkt_cnt1};
  endfunction
  function automatic logic [35:0] mk(input logic a, input logic [7:0] b, input logic c,
      input logic e, input logic [7:0] f, input logic g, input logic [7:0] h, input logic [7:0] k);
    return {a, b, c, e, f, g, h, k};
  endfunction
  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic s,
      input logic r0, input logic r1, input logic rdy, input logic [35:0] exp);
    q.push_back('{v, d, l, s, r0, r1, rdy, exp});
  endtask
  task automatic chk_rdy(input string nm, input logic exp);
    n_vec++;
    if (s_ready !== exp) begin
      n_bad++;
      $display("FAIL %s s_ready got %b want %b", nm, s_ready, exp);
    end
  endtask
  task automatic chk_out(input string nm, input logic [35:0] exp);
    n_vec++;
    if (outs() !== exp) begin
      n_bad++;
      $display("FAIL %s outs{m0v,m0d,m0l,m1v,m1d,m1l,c0,c1} got %h want %h", nm, outs(), exp);
    end
  endtask
  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic s,
      input logic r0, input logic r1);
    @(negedge clk);
    s_valid = v; s_data = d; s_last = l; sel = s; m0_ready = r0; m1_ready = r1;
    #1;
  endtask
  initial begin
    // single-beat packet to m1, then drain
    add(1, 8'hA5, 1, 1, 1, 1, 1, mk(0, 8'h00, 0, 1, 8'hA5, 1, 0, 0));
    add(0, 8'h00, 0, 1, 1, 1, 1, mk(0, 8'h00, 0, 0, 8'hA5, 1, 0, 1));
    // 3-beat packet locked to m0 despite sel toggling
    add(1, 8'h11, 0, 0, 1, 1, 1, mk(1, 8'h11, 0, 0, 8'hA5, 1, 0, 1));
    add(1, 8'h22, 0, 1, 1, 1, 1, mk(1, 8'h22, 0, 0, 8'hA5, 1, 0, 1));
    add(1, 8'h33, 1, 1, 1, 1, 1, mk(1, 8'h33, 1, 0, 8'hA5, 1, 0, 1));
    add(0, 8'h00, 0, 0, 1, 1, 1, mk(0, 8'h33, 1, 0, 8'hA5, 1, 1, 1));
    // backpressure on m0
    add(1, 8'h44, 0, 0, 0, 1, 1, mk(1, 8'h44, 0, 0, 8'hA5, 1, 1, 1));
    add(1, 8'h55, 0, 0, 0, 1, 0, mk(1, 8'h44, 0, 0, 8'hA5, 1, 1, 1));
    add(1, 8'h55, 0, 1, 0, 1, 0, mk(1, 8'h44, 0, 0, 8'hA5, 1, 1, 1));
    add(1, 8'h55, 0, 1, 1, 1, 1, mk(1, 8'h55, 0, 0, 8'hA5, 1, 1, 1));
    add(1, 8'h66, 1, 1, 1, 1, 1, mk(1, 8'h66, 1, 0, 8'hA5, 1, 1, 1));
    add(0, 8'h00, 0, 0, 1, 1, 1, mk(0, 8'h66, 1, 0, 8'hA5, 1, 2, 1));
    // m1 keeps flowing while m0 is stalled
    add(1, 8'h77, 1, 0, 0, 1, 1, mk(1, 8'h77, 1, 0, 8'hA5, 1, 2, 1));
    add(1, 8'h88, 1, 1, 0, 1, 1, mk(1, 8'h77, 1, 1, 8'h88, 1, 2, 1));
    add(1, 8'h99, 0, 1, 0, 1, 1, mk(1, 8'h77, 1, 1, 8'h99, 0, 2, 2));
    add(1, 8'hAA, 1, 0, 0, 1, 1, mk(1, 8'h77, 1, 1, 8'hAA, 1, 2, 2));
    add(0, 8'h00, 0, 1, 0, 0, 0, mk(1, 8'h77, 1, 1, 8'hAA, 1, 2, 2));
    add(0, 8'h00, 0, 0, 1, 1, 1, mk(0, 8'h77, 1, 0, 8'hAA, 1, 3, 3));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_rdy("reset_rdy", 1'b0);
    chk_out("reset_outs", '0);
    rst = 0;
    foreach (q[i]) begin
      drive(q[i].v, q[i].d, q[i].l, q[i].sel, q[i].r0, q[i].r1);
      chk_rdy($sformatf("vec%0d_rdy", i), q[i].rdy);
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d_outs", i), q[i].exp);
    end
    // reset in the middle of a 4-beat packet to m1
    drive(1, 8'h01, 0, 1, 1, 0);
    @(posedge clk); #1;
    drive(1, 8'h02, 0, 0, 1, 1);
    chk_rdy("midrst_b2_rdy", 1'b1);
    @(posedge clk); #1;
    chk_out("midrst_b2_outs", mk(0, 8'h77, 1, 1, 8'h02, 0, 3, 3));
    drive(0, 8'h00, 0, 1, 1, 0);
    rst = 1;
    #1 chk_rdy("midrst_rdy", 1'b0);
    @(posedge clk); #1;
    chk_out("midrst_outs", '0);
    drive(1, 8'hBB, 1, 0, 0, 0);
    rst = 0;
    #1 chk_rdy("postrst_rdy", 1'b1);
    @(posedge clk); #1;
    chk_out("postrst_outs", mk(1, 8'hBB, 1, 0, 8'h00, 0, 0, 0));
    drive(0, 8'h00, 0, 0, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    // 256 back-to-back single-beat packets to m0
    for (int i = 1; i <= 256; i++) begin
      drive(1, 8'(i), 1, 0, 1, 0);
      if (i == 1 || i == 256) chk_rdy($sformatf("wrap%0d_rdy", i), 1'b1);
      @(posedge clk); #1;
      if (i == 256) chk_out("wrap255", mk(1, 8'h00, 1, 0, 8'h00, 0, 8'd255, 0));
    end
    drive(0, 8'h00, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk_out("wrap0", mk(0, 8'h00, 1, 0, 8'h00, 0, 8'd0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
